// File: rtl/bram_wr_arbiter_pkg.sv
// rtl/bram_wr_arbiter_pkg.sv - shared state and requester encodings for the BRAM write arbiter
package bram_wr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   // One-hot grant vector for a requester id (bit 0 = CPU, bit 1 = debug).
   function automatic logic [1:0] gnt_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/bram_wr_arbiter_if.sv
// rtl/bram_wr_arbiter_if.sv - requester, clear-control and BRAM write-port bundle
interface bram_wr_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);

   logic                  i_req0;
   logic [ADDR_WIDTH-1:0] i_addr0;
   logic [DATA_WIDTH-1:0] i_data0;
   logic                  o_gnt0;

   logic                  i_req1;
   logic [ADDR_WIDTH-1:0] i_addr1;
   logic [DATA_WIDTH-1:0] i_data1;
   logic                  o_gnt1;

   logic                  i_clr_start;
   logic                  o_busy;
   logic                  o_clr_done;

   logic                  o_we;
   logic [ADDR_WIDTH-1:0] o_waddr;
   logic [DATA_WIDTH-1:0] o_di;

   modport master (
      output i_req0, i_addr0, i_data0,
      output i_req1, i_addr1, i_data1,
      output i_clr_start,
      input  o_gnt0, o_gnt1, o_busy, o_clr_done,
      input  o_we, o_waddr, o_di
   );

   modport slave (
      input  i_req0, i_addr0, i_data0,
      input  i_req1, i_addr1, i_data1,
      input  i_clr_start,
      output o_gnt0, o_gnt1, o_busy, o_clr_done,
      output o_we, o_waddr, o_di
   );

endinterface

// File: rtl/bram_wr_arbiter_rr_arb2.sv
// rtl/bram_wr_arbiter_rr_arb2.sv - two-input write arbiter, round-robin when BRAM_ARB_RR_EN is defined
module bram_rr_arb2
   import bram_wr_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

`ifdef BRAM_ARB_RR_EN
   logic last_q;
   logic last_d;

   // Tie goes to whoever did not win last; pointer moves only on a real grant.
   always_comb begin
      o_gnt  = 2'b00;
      last_d = last_q;
      if (i_req == 2'b11) begin
         o_gnt = gnt_onehot(~last_q);
      end else begin
         o_gnt = i_req;
      end
      if (o_gnt[REQ_CPU]) begin
         last_d = REQ_CPU;
      end else if (o_gnt[REQ_DBG]) begin
         last_d = REQ_DBG;
      end
   end

   // Last-grant pointer; reset to debug so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         last_q <= REQ_DBG;
      end else begin
         last_q <= last_d;
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ i_rst;

   // Fixed priority: the CPU store path always wins a tie.
   always_comb begin
      o_gnt = 2'b00;
      if (i_req[REQ_CPU]) begin
         o_gnt = gnt_onehot(REQ_CPU);
      end else if (i_req[REQ_DBG]) begin
         o_gnt = gnt_onehot(REQ_DBG);
      end
   end
`endif

endmodule

// File: rtl/bram_wr_arbiter.sv
// rtl/bram_wr_arbiter.sv - BRAM write-port owner: CPU/debug arbitration plus clear sweep (BRAM_ARB_RR_EN selects round-robin)
module bram_wr_arbiter
   import bram_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic               clk,
   input  logic               i_rst,
   bram_wr_arbiter_if.slave   bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] di_q, di_d;
   logic                  done_q, done_d;

   logic [1:0]            arb_req;
   logic [1:0]            arb_gnt;

   // Requests reach the arbiter only in IDLE without a clear launch, so its pointer sees real grants only.
   always_comb begin
      arb_req = 2'b00;
      if ((state_q == ST_IDLE) && !bus.i_clr_start) begin
         arb_req = {bus.i_req1, bus.i_req0};
      end
   end

   bram_rr_arb2 u_arb (
      .clk   (clk),
      .i_rst (i_rst),
      .i_req (arb_req),
      .o_gnt (arb_gnt)
   );

   assign bus.o_gnt0     = arb_gnt[REQ_CPU];
   assign bus.o_gnt1     = arb_gnt[REQ_DBG];
   assign bus.o_busy     = (state_q == ST_CLEAR);
   assign bus.o_clr_done = done_q;
   assign bus.o_we       = we_q;
   assign bus.o_waddr    = waddr_q;
   assign bus.o_di       = di_q;

   // Next-state and next write-port values; address/data hold when nothing is written.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      di_d    = di_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_clr_start) begin
               state_d = ST_CLEAR;
            end else if (arb_gnt[REQ_CPU]) begin
               we_d    = 1'b1;
               waddr_d = bus.i_addr0;
               di_d    = bus.i_data0;
            end else if (arb_gnt[REQ_DBG]) begin
               we_d    = 1'b1;
               waddr_d = bus.i_addr1;
               di_d    = bus.i_data1;
            end
         end
         ST_CLEAR: begin
            we_d    = 1'b1;
            waddr_d = cnt_q;
            di_d    = '0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   // State and registered write port; reset aborts a sweep without a done pulse.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         di_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         di_q    <= di_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// tb/tb_bram_wr_arbiter.sv - self-checking bench for bram_wr_arbiter (honours BRAM_ARB_RR_EN)
module tb_bram_wr_arbiter;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 2**AW;

   typedef struct packed {
      logic          g0;
      logic          g1;
      logic          done;
      logic          busy;
      logic          we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] di;
   } obs_t;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   bram_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   bram_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM behind the write port
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (bus.o_we === 1'b1) ram[bus.o_waddr] <= bus.o_di;
   end

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   logic          exp_we;
   logic [AW-1:0] exp_waddr;
   logic [DW-1:0] exp_di;
   logic          exp_done;
   int            sweep_left;
   int            last_win;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check against the model, advance the model, step past the edge.
   task automatic tick(input logic rst_i, input logic clr,
                       input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output obs_t o);
      int win;
      rst             = rst_i;
      bus.i_clr_start = clr;
      bus.i_req0      = r0;
      bus.i_addr0     = a0;
      bus.i_data0     = d0;
      bus.i_req1      = r1;
      bus.i_addr1     = a1;
      bus.i_data1     = d1;
      #3;
      o.g0    = bus.o_gnt0;
      o.g1    = bus.o_gnt1;
      o.done  = bus.o_clr_done;
      o.busy  = bus.o_busy;
      o.we    = bus.o_we;
      o.waddr = bus.o_waddr;
      o.di    = bus.o_di;
      chk1 ("o_we", bus.o_we, exp_we);
      chk32("o_waddr", 32'(bus.o_waddr), 32'(exp_waddr));
      chk32("o_di", bus.o_di, exp_di);
      chk1 ("o_clr_done", bus.o_clr_done, exp_done);
      chk1 ("o_busy", bus.o_busy, sweep_left > 0);
      if (rst_i) begin
         o.g0       = 1'b0;
         o.g1       = 1'b0;
         exp_we     = 1'b0;
         exp_waddr  = '0;
         exp_di     = '0;
         exp_done   = 1'b0;
         sweep_left = 0;
         last_win   = 1;
      end else if (sweep_left > 0) begin
         chk1("sweep_gnt0", bus.o_gnt0, 1'b0);
         chk1("sweep_gnt1", bus.o_gnt1, 1'b0);
         exp_we     = 1'b1;
         exp_waddr  = AW'(DEPTH - sweep_left);
         exp_di     = '0;
         ref_mem[DEPTH - sweep_left] = '0;
         sweep_left = sweep_left - 1;
         exp_done   = (sweep_left == 0);
      end else if (clr) begin
         chk1("clr_gnt0", bus.o_gnt0, 1'b0);
         chk1("clr_gnt1", bus.o_gnt1, 1'b0);
         exp_we     = 1'b0;
         exp_done   = 1'b0;
         sweep_left = DEPTH;
      end else begin
         if (r0 && r1) begin
`ifdef BRAM_ARB_RR_EN
            win = 1 - last_win;
`else
            win = 0;
`endif
         end else if (r0) begin
            win = 0;
         end else if (r1) begin
            win = 1;
         end else begin
            win = -1;
         end
         chk1("gnt0", bus.o_gnt0, win == 0);
         chk1("gnt1", bus.o_gnt1, win == 1);
         exp_done = 1'b0;
         if (win == 0) begin
            exp_we = 1'b1; exp_waddr = a0; exp_di = d0; ref_mem[a0] = d0; last_win = 0;
         end else if (win == 1) begin
            exp_we = 1'b1; exp_waddr = a1; exp_di = d1; ref_mem[a1] = d1; last_win = 1;
         end else begin
            exp_we = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      obs_t o;
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, o);
   endtask

   initial begin
      obs_t          o;
      int            busy_cnt, done_cnt, n;
      logic          got, done_at, exp_g0, p0, p1, clr;
      logic [AW-1:0] a0r, a1r;
      logic [DW-1:0] d0r, d1r;

      rst = 1'b1;
      bus.i_clr_start = 1'b0;
      bus.i_req0 = 1'b0; bus.i_addr0 = '0; bus.i_data0 = '0;
      bus.i_req1 = 1'b0; bus.i_addr1 = '0; bus.i_data1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk1 ("rst_we", bus.o_we, 1'b0);
      chk32("rst_waddr", 32'(bus.o_waddr), 32'h0);
      chk32("rst_di", bus.o_di, 32'h0);
      chk1 ("rst_busy", bus.o_busy, 1'b0);
      chk1 ("rst_done", bus.o_clr_done, 1'b0);
      exp_we = 1'b0; exp_waddr = '0; exp_di = '0; exp_done = 1'b0;
      sweep_left = 0; last_win = 1;

      // Full clear sweep
      busy_cnt = 0; done_cnt = 0;
      tick(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, o);
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, o);
         busy_cnt += int'(o.busy);
         done_cnt += int'(o.done);
      end
      chk32("clr_busy_cycles", busy_cnt, 16);
      chk32("clr_done_pulses", done_cnt, 1);
      for (int i = 0; i < DEPTH; i++) chk32("clr_mem_zero", ram[i], 32'h0);

      // Debug write after clear: only its address becomes nonzero
      tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'h3, 32'h1234_5678, o);
      chk1("dbg_gnt1", o.g1, 1'b1);
      idle(2);
      for (int i = 0; i < DEPTH; i++)
         chk32("retarget_mem", ram[i], (i == 3) ? 32'h1234_5678 : 32'h0);

      // Contention for four cycles; debug won last so the CPU takes the first tie
      d0r = 32'hA0A0_0000; d1r = 32'hB1B1_B1B1;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b1, 4'h5, d0r, 1'b1, 4'h6, d1r, o);
`ifdef BRAM_ARB_RR_EN
         exp_g0 = ((i % 2) == 0);
`else
         exp_g0 = 1'b1;
`endif
         chk1("tie_gnt0", o.g0, exp_g0);
         chk1("tie_gnt1", o.g1, !exp_g0);
         if (o.g0) d0r = d0r + 32'h1;
      end
      idle(2);

      // Single CPU write and read-back
      tick(1'b0, 1'b0, 1'b1, 4'hA, 32'hDEAD_BEEF, 1'b0, '0, '0, o);
      chk1("single_gnt0", o.g0, 1'b1);
      chk1("single_gnt1", o.g1, 1'b0);
      idle(0);
      tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, o);
      chk1 ("single_we", o.we, 1'b1);
      chk32("single_waddr", 32'(o.waddr), 32'hA);
      chk32("single_di", o.di, 32'hDEAD_BEEF);
      idle(1);
      chk32("single_mem", ram[10], 32'hDEAD_BEEF);

      // Clear and debug request in the same cycle: grant waits until the done cycle
      tick(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 4'h7, 32'hC0FF_EE01, o);
      chk1("clr_req_nogrant", o.g1, 1'b0);
      n = 0; got = 1'b0; done_at = 1'b0;
      while (!got && n < 40) begin
         tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'h7, 32'hC0FF_EE01, o);
         n++;
         if (o.g1) begin
            got = 1'b1;
            done_at = o.done;
         end
      end
      chk1 ("clr_req_grant_seen", got, 1'b1);
      chk1 ("clr_req_grant_on_done", done_at, 1'b1);
      chk32("clr_req_wait", n, 17);
      idle(2);

      // Reset while the sweep counter is at 5
      tick(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, o);
      idle(5);
      tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, o);
      tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, o);
      chk1("rst_mid_we", o.we, 1'b0);
      chk1("rst_mid_busy", o.busy, 1'b0);
      chk1("rst_mid_done", o.done, 1'b0);
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, o);
         done_cnt += int'(o.done);
      end
      chk32("rst_mid_no_done", done_cnt, 0);

      // A new sweep restarts from address 0
      tick(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, o);
      idle(1);
      tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, o);
      chk1 ("restart_we", o.we, 1'b1);
      chk32("restart_addr", 32'(o.waddr), 32'h0);
      idle(18);

      // Randomized traffic with occasional clear requests
      p0 = 1'b0; p1 = 1'b0;
      a0r = '0; a1r = '0; d0r = '0; d1r = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && ($urandom_range(0, 9) < 6)) begin
            p0 = 1'b1; a0r = AW'($urandom); d0r = $urandom;
         end
         if (!p1 && ($urandom_range(0, 9) < 6)) begin
            p1 = 1'b1; a1r = AW'($urandom); d1r = $urandom;
         end
         clr = ($urandom_range(0, 49) == 0);
         tick(1'b0, clr, p0, a0r, d0r, p1, a1r, d1r, o);
         if (o.g0) p0 = 1'b0;
         if (o.g1) p1 = 1'b0;
      end
      idle(20);
      for (int i = 0; i < DEPTH; i++) chk32("final_mem", ram[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
